// File: rtl/mat4_vec4_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mat4_vec4_seq_pkg
// Description : Shared Q8.8 constants, sequencer state encoding and the
//               matrix row-select helper for the mat4 x vec4 transform.
// Revision    : 1.0 - initial release
// ============================================================================
package mat4_vec4_seq_pkg;

    localparam int Q88_W = 16;
    localparam logic [Q88_W-1:0] Q88_ONE = 16'h0100;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_GUARD = 3'd2,
        ST_WAIT  = 3'd3,
        ST_FIN   = 3'd4
    } state_t;

    // 4:1 row select on a row-major 4x4 matrix. Element c of the returned
    // row sits at bits [16*c +: 16], so column 0 is the least significant.
    function automatic logic [4*Q88_W-1:0] get_row(
        input logic [16*Q88_W-1:0] m,
        input logic [1:0]          r
    );
        logic [4*Q88_W-1:0] row;
        row = m[0 +: 4*Q88_W];
        case (r)
            2'd0: row = m[0*4*Q88_W +: 4*Q88_W];
            2'd1: row = m[1*4*Q88_W +: 4*Q88_W];
            2'd2: row = m[2*4*Q88_W +: 4*Q88_W];
            2'd3: row = m[3*4*Q88_W +: 4*Q88_W];
            default: row = m[0 +: 4*Q88_W];
        endcase
        return row;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mat4_vec4_seq.sv
`default_nettype none
// ============================================================================
// Module      : mat4_vec4_seq
// Description : Q8.8 4x4 matrix x 4-vector sequencer (out = M * v). Issues one
//               job per matrix row to an external, shareable dot4 unit over a
//               start/done handshake and collects the row results.
// Ports       : clk, reset         - clock, synchronous active-high reset
//               start_i            - request a transform (taken only when idle)
//               m_i                - row-major matrix, M[r][c] at 16*(4r+c)
//               v_*_i              - input vector
//               busy_o, done_o     - job in flight / result valid (held)
//               out_*_o            - result rows 0..3
//               dot_start_o        - one-cycle dot4 job request
//               dot_v1_*_o         - matrix row operand
//               dot_v2_*_o         - vector operand
//               dot_done_i         - dot4 done level
//               dot_result_i       - dot4 Q8.8 result
// Parameters  : W      - word width, only 16 supported
//               AFFINE - 1: three rows only, out_w forced to 1.0
// Revision    : 1.0 - initial release
// ============================================================================
module mat4_vec4_seq
    import mat4_vec4_seq_pkg::*;
#(
    parameter int W      = 16,
    parameter bit AFFINE = 1'b0
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start_i,
    input  logic [16*W-1:0] m_i,
    input  logic [W-1:0]  v_x_i,
    input  logic [W-1:0]  v_y_i,
    input  logic [W-1:0]  v_z_i,
    input  logic [W-1:0]  v_w_i,
    output logic          busy_o,
    output logic          done_o,
    output logic [W-1:0]  out_x_o,
    output logic [W-1:0]  out_y_o,
    output logic [W-1:0]  out_z_o,
    output logic [W-1:0]  out_w_o,
    output logic          dot_start_o,
    output logic [W-1:0]  dot_v1_x_o,
    output logic [W-1:0]  dot_v1_y_o,
    output logic [W-1:0]  dot_v1_z_o,
    output logic [W-1:0]  dot_v1_w_o,
    output logic [W-1:0]  dot_v2_x_o,
    output logic [W-1:0]  dot_v2_y_o,
    output logic [W-1:0]  dot_v2_z_o,
    output logic [W-1:0]  dot_v2_w_o,
    input  logic          dot_done_i,
    input  logic [W-1:0]  dot_result_i
);

    localparam logic [1:0] LAST_ROW = AFFINE ? 2'd2 : 2'd3;

    state_t              state_q;
    logic [1:0]          row_q;
    logic                busy_q;
    logic                done_q;
    logic                dot_start_q;
    logic [3:0][W-1:0]   out_q;
    logic [4*W-1:0]      dot_v1_q;
    logic [4*W-1:0]      dot_v2_q;

    logic [1:0]          row_nxt_d;
    logic [4*W-1:0]      vec_d;

    assign row_nxt_d = row_q + 2'd1;
    assign vec_d     = {v_w_i, v_z_i, v_y_i, v_x_i};

    // All outputs are registered; dot_start and the operands are loaded on
    // entry to ISSUE so the request is visible exactly during the ISSUE cycle
    // and the operands stay stable through GUARD and WAIT.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            row_q       <= 2'd0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            dot_start_q <= 1'b0;
            out_q       <= '0;
            dot_v1_q    <= '0;
            dot_v2_q    <= '0;
        end else begin
            dot_start_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start_i) begin
                        done_q      <= 1'b0;
                        busy_q      <= 1'b1;
                        row_q       <= 2'd0;
                        dot_v1_q    <= get_row(m_i, 2'd0);
                        dot_v2_q    <= vec_d;
                        dot_start_q <= 1'b1;
                        state_q     <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    state_q <= ST_GUARD;
                end
                ST_GUARD: begin
                    // dot_done may still be high from the previous job here;
                    // dot4 only drops it once it has taken the new start.
                    state_q <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (dot_done_i) begin
                        out_q[row_q] <= dot_result_i;
                        if (row_q == LAST_ROW) begin
                            state_q <= ST_FIN;
                        end else begin
                            row_q       <= row_nxt_d;
                            dot_v1_q    <= get_row(m_i, row_nxt_d);
                            dot_v2_q    <= vec_d;
                            dot_start_q <= 1'b1;
                            state_q     <= ST_ISSUE;
                        end
                    end
                end
                ST_FIN: begin
                    done_q <= 1'b1;
                    busy_q <= 1'b0;
                    if (AFFINE) begin
                        out_q[3] <= Q88_ONE;
                    end
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign dot_start_o = dot_start_q;
    assign out_x_o     = out_q[0];
    assign out_y_o     = out_q[1];
    assign out_z_o     = out_q[2];
    assign out_w_o     = out_q[3];
    assign dot_v1_x_o  = dot_v1_q[0*W +: W];
    assign dot_v1_y_o  = dot_v1_q[1*W +: W];
    assign dot_v1_z_o  = dot_v1_q[2*W +: W];
    assign dot_v1_w_o  = dot_v1_q[3*W +: W];
    assign dot_v2_x_o  = dot_v2_q[0*W +: W];
    assign dot_v2_y_o  = dot_v2_q[1*W +: W];
    assign dot_v2_z_o  = dot_v2_q[2*W +: W];
    assign dot_v2_w_o  = dot_v2_q[3*W +: W];

endmodule
`default_nettype wire
